// File: rtl/kanagawa_memory_rmw_pkg.sv
// kanagawa_memory_rmw_pkg
// Shared types for the read-modify-write front end.
//   rmw_op_t    : atomic operation encoding
//   rmw_stage_t : one entry of the valid-tagged request pipeline
// The stage struct is sized by RMW_DATA_WIDTH / RMW_ADDR_WIDTH. The top
// level rejects any other width at elaboration.
package kanagawa_memory_rmw_pkg;

  localparam int RMW_DATA_WIDTH = 32;
  localparam int RMW_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ADD   = 2'b10,
    OP_SUB   = 2'b11
  } rmw_op_t;

  typedef struct packed {
    logic                      valid;
    rmw_op_t                   op;
    logic [RMW_ADDR_WIDTH-1:0] addr;
    logic [RMW_DATA_WIDTH-1:0] operand;
  } rmw_stage_t;

endpackage

// File: rtl/kanagawa_memory_rmw_if.sv
// kanagawa_memory_rmw_if
// Request, RAM and response bundle of the RMW front end.
//   slave  : the RMW block (consumes requests and read data, drives the rest)
//   master : the environment (requester, RAM with bypass, response sink)
interface kanagawa_memory_rmw_if
  import kanagawa_memory_rmw_pkg::*;
#(
  parameter int DATA_WIDTH = RMW_DATA_WIDTH,
  parameter int ADDR_WIDTH = RMW_ADDR_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  rmw_op_t               req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_operand;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  ram_wren;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_old_data;
  logic [DATA_WIDTH-1:0] rsp_new_data;
  logic                  init_done;

  modport slave (
    input  req_valid, req_op, req_addr, req_operand, ram_rd_data,
    output req_ready, ram_rd_addr, ram_wren, ram_wr_addr, ram_wr_data,
           rsp_valid, rsp_old_data, rsp_new_data, init_done
  );

  modport master (
    output req_valid, req_op, req_addr, req_operand, ram_rd_data,
    input  req_ready, ram_rd_addr, ram_wren, ram_wr_addr, ram_wr_data,
           rsp_valid, rsp_old_data, rsp_new_data, init_done
  );

endinterface

// File: rtl/kanagawa_memory_rmw_alu.sv
// kanagawa_memory_rmw_alu
// Combinational update of one word: (op, old, operand) -> new.
//   i_op      : operation
//   i_old     : current (bypass-corrected) word value
//   i_operand : request operand
//   o_new     : word value after the operation
// Macro KANAGAWA_MEMORY_RMW_SATURATE_EN: ADD clamps to all-ones on carry,
// SUB clamps to zero on borrow. Without it both wrap.
module kanagawa_memory_rmw_alu
  import kanagawa_memory_rmw_pkg::*;
#(
  parameter int DATA_WIDTH = RMW_DATA_WIDTH
) (
  input  rmw_op_t               i_op,
  input  logic [DATA_WIDTH-1:0] i_old,
  input  logic [DATA_WIDTH-1:0] i_operand,
  output logic [DATA_WIDTH-1:0] o_new
);

`ifdef KANAGAWA_MEMORY_RMW_SATURATE_EN
  // One extra bit holds the carry (ADD) or borrow (SUB).
  logic [DATA_WIDTH:0] w_sum;
  logic [DATA_WIDTH:0] w_diff;
  assign w_sum  = {1'b0, i_old} + {1'b0, i_operand};
  assign w_diff = {1'b0, i_old} - {1'b0, i_operand};
`else
  logic [DATA_WIDTH-1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_diff;
  assign w_sum  = i_old + i_operand;
  assign w_diff = i_old - i_operand;
`endif

  always_comb begin
    o_new = i_old;
    case (i_op)
      OP_READ:  o_new = i_old;
      OP_WRITE: o_new = i_operand;
`ifdef KANAGAWA_MEMORY_RMW_SATURATE_EN
      OP_ADD:   o_new = w_sum[DATA_WIDTH]  ? '1 : w_sum[DATA_WIDTH-1:0];
      OP_SUB:   o_new = w_diff[DATA_WIDTH] ? '0 : w_diff[DATA_WIDTH-1:0];
`else
      OP_ADD:   o_new = w_sum;
      OP_SUB:   o_new = w_diff;
`endif
      default:  o_new = i_old;
    endcase
  end

endmodule

// File: rtl/kanagawa_memory_rmw.sv
// kanagawa_memory_rmw
// Fixed-latency read-modify-write front end for a RAM whose read path carries
// a write-bypass stage. After reset it sweeps INIT_VALUE into words
// 0..DEPTH-1, then accepts one READ/WRITE/ADD/SUB per cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : kanagawa_memory_rmw_if.slave
//                req_*  request handshake (req_ready high only in RUN)
//                ram_*  RAM read address/data, write port (mirrored to bypass)
//                rsp_*  response strobe with old/new word values
//                init_done sweep complete
// Optional macro: KANAGAWA_MEMORY_RMW_SATURATE_EN (saturating ADD/SUB).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_INIT | sweep writes INIT_VALUE at r_cnt; one idle cycle after last
// ST_RUN  | accept requests, emit write + response READ_LATENCY+1 later
module kanagawa_memory_rmw
  import kanagawa_memory_rmw_pkg::*;
#(
  parameter int                    DATA_WIDTH   = RMW_DATA_WIDTH,
  parameter int                    ADDR_WIDTH   = RMW_ADDR_WIDTH,
  parameter int                    DEPTH        = 2 ** ADDR_WIDTH,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input logic                  clk,
  input logic                  rst_n,
  kanagawa_memory_rmw_if.slave bus
);

  if (DATA_WIDTH != RMW_DATA_WIDTH || ADDR_WIDTH != RMW_ADDR_WIDTH) begin : g_bad_width
    $error("kanagawa_memory_rmw: widths must match kanagawa_memory_rmw_pkg");
  end
  if (DEPTH < 1 || DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("kanagawa_memory_rmw: DEPTH out of range");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("kanagawa_memory_rmw: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                r_state;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic                  r_ready;
  logic                  r_done;
  logic                  r_wren;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_old;
  logic [DATA_WIDTH-1:0] r_new;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  rmw_stage_t            r_stage [READ_LATENCY];

  logic                  w_accept;
  rmw_stage_t            w_tail;
  logic [DATA_WIDTH-1:0] w_new;

  assign w_accept = bus.req_valid && r_ready;
  assign w_tail   = r_stage[READ_LATENCY-1];

  // Read address is live in the accept cycle and parked otherwise.
  assign bus.ram_rd_addr  = w_accept ? bus.req_addr : r_rd_addr;
  assign bus.req_ready    = r_ready;
  assign bus.init_done    = r_done;
  assign bus.ram_wren     = r_wren;
  assign bus.ram_wr_addr  = r_wr_addr;
  assign bus.ram_wr_data  = r_wr_data;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_old_data = r_old;
  assign bus.rsp_new_data = r_new;

  kanagawa_memory_rmw_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_op      (w_tail.op),
    .i_old     (bus.ram_rd_data),
    .i_operand (w_tail.operand),
    .o_new     (w_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_ready     <= 1'b0;
      r_done      <= 1'b0;
      r_wren      <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rsp_valid <= 1'b0;
      r_old       <= '0;
      r_new       <= '0;
      r_rd_addr   <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= '{valid: w_accept, op: bus.req_op, addr: bus.req_addr,
                      operand: bus.req_operand};
      for (int i = 1; i < READ_LATENCY; i++) r_stage[i] <= r_stage[i-1];
      if (w_accept) r_rd_addr <= bus.req_addr;

      case (r_state)
        ST_INIT: begin
          r_rsp_valid <= 1'b0;
          if (r_cnt != LP_DEPTH) begin
            r_wren    <= 1'b1;
            r_wr_addr <= r_cnt[ADDR_WIDTH-1:0];
            r_wr_data <= INIT_VALUE;
            r_cnt     <= r_cnt + 1'b1;
          end else begin
            // Write DEPTH-1 is on the port this cycle; open for requests next.
            r_wren  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_wren      <= w_tail.valid && (w_tail.op != OP_READ);
          r_rsp_valid <= w_tail.valid;
          if (w_tail.valid) begin
            r_wr_addr <= w_tail.addr;
            r_wr_data <= w_new;
            r_old     <= bus.ram_rd_data;
            r_new     <= w_new;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  a_addr_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    w_accept |-> ({1'b0, bus.req_addr} < LP_DEPTH));

endmodule

// File: doc/kanagawa_memory_rmw.md
# kanagawa_memory_rmw

Fixed-latency read-modify-write front end for a single-port-pair RAM with a write-bypass stage on its read path. Accepts one atomic request per cycle (READ, WRITE, ADD, SUB). Drives the RAM read address and consumes the bypass-corrected read data. Drives the RAM write port, which is also mirrored into the bypass stage. After reset, an init sweep writes INIT_VALUE to every word before requests are accepted.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 10, address width
- DEPTH, 2**ADDR_WIDTH, words swept by init; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_WIDTH
- READ_LATENCY, 1, cycles from ram_rd_addr to ram_rd_data; 1 or 2
- INIT_VALUE, '0, value written to every word after reset
- clk  in  1  sole clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in RUN state
- req_op  in  2  operation, rmw_op_t
- req_addr  in  ADDR_WIDTH  target word
- req_operand  in  DATA_WIDTH  operand
- ram_rd_addr  out  ADDR_WIDTH  RAM read address
- ram_rd_data  in  DATA_WIDTH  read data after bypass correction
- ram_wren  out  1  RAM and bypass write enable
- ram_wr_addr  out  ADDR_WIDTH  write address
- ram_wr_data  out  DATA_WIDTH  write data
- rsp_valid  out  1  response strobe
- rsp_old_data  out  DATA_WIDTH  word value before the operation
- rsp_new_data  out  DATA_WIDTH  word value after the operation
- init_done  out  1  sweep complete

## Operation
- Ops: READ=2'b00 (new=old, no write); WRITE=2'b01 (new=operand); ADD=2'b10 (new=old+operand); SUB=2'b11 (new=old−operand).
- ADD/SUB are modulo 2**DATA_WIDTH unless saturation is enabled.
- FSM states: INIT and RUN. Reset enters INIT with sweep counter 0.
- INIT: each cycle assert ram_wren with ram_wr_addr=counter and ram_wr_data=INIT_VALUE, then increment the counter.
- The cycle that writes DEPTH−1 transitions to RUN. init_done is set and remains 1 until the next reset.
- RUN: a request is accepted on req_valid && req_ready. ram_rd_addr = req_addr combinationally in the accept cycle; otherwise ram_rd_addr holds its last value.
- op, addr and operand travel through a READ_LATENCY-deep valid-tagged shift register.
- When the tagged stage aligns with ram_rd_data, compute new data. Register ram_wren (0 for READ), ram_wr_addr, ram_wr_data, rsp_valid, rsp_old_data and rsp_new_data.
- Back-to-back hazards on the same address rely on the downstream bypass. That bypass is configured with read address presented early, data not early, and NUM_BYPASS_SLOTS = READ_LATENCY+1.
- req_addr ≥ DEPTH: simulation assertion fires; the response is unspecified.

## Timing
- Reset values: req_ready=0, init_done=0, ram_wren=0, rsp_valid=0. All address and data outputs are 0.
- Reset asserted mid-sweep or mid-pipeline clears all valid tags, drops in-flight requests without a response, and restarts INIT.
- The first INIT write occurs in the first clock edge cycle after rst_n deasserts. INIT lasts exactly DEPTH cycles.
- req_ready rises the cycle after the last INIT write.
- Request accepted at cycle T: rsp_valid and ram_wren are asserted at T+READ_LATENCY+1.
- Throughput is 1 request per cycle with no bubbles, including repeated same-address ADDs.
- There is no backpressure on responses; the consumer must accept rsp every cycle.

## Configuration
- KANAGAWA_MEMORY_RMW_SATURATE_EN defined: ADD clamps to 2**DATA_WIDTH−1 on carry, and SUB clamps to 0 on borrow.
- Undefined: ADD and SUB wrap modulo 2**DATA_WIDTH.
- READ and WRITE are identical in both builds.

## Structure
- kanagawa_memory_rmw_pkg holds the rmw_op_t enum with its encodings and the rmw_stage_t packed struct {valid, op, addr, operand}.
- Sub-module kanagawa_memory_rmw_alu is purely combinational: (op, old, operand) → new. Saturation is selected inside it by the macro.
- The top level holds the FSM, sweep counter, stage shift register and output registers.

## Test plan
- Reset with DEPTH=16: ram_wren is high for exactly 16 cycles over addresses 0..15. req_ready rises the following cycle, then a READ of address 5 returns old=new=INIT_VALUE.
- WRITE 0x10 to address 3, then READ address 3 next cycle: the READ returns old=0x10, no write.
- Eight back-to-back ADD 1 to address 7 from 0: responses old=0..7, new=1..8, one per cycle, with L+1 latency at READ_LATENCY=1 and 2.
- ADD 5 to 0xFFFFFFFE: new=0x00000003 without the macro, 0xFFFFFFFF with it. SUB 1 from 0: new=0xFFFFFFFF without, 0 with.
- Assert rst_n low for one cycle during the sweep and during a pipelined ADD: no rsp_valid for the dropped request, and the sweep restarts at address 0.
